outport_uart_tx: RTL and testbench
==================================

// Module: outport_uart_tx
// PURPOSE
//  Serialises words written to the CPU output port onto a UART TX line (8N1).
//  Sits downstream of the datapath output port and consumes each word written there.
//  wr_en is driven by the control unit's output-port enable; wr_data is the output-port word.
//  A small word FIFO decouples CPU writes from the slow line.
//  Each word is sent as 4 bytes: byte 0 (bits 7:0) first, byte 3 (bits 31:24) last.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); legal range >= 2
//  FIFO_DEPTH    4    word entries; must be a power of two, >= 2
//  FIFO_AW       2    log2(FIFO_DEPTH)
// PORTS
//  clk        in   1              single clock; all state changes on its rising edge
//  rst        in   1              asynchronous, active-low reset
//  wr_en      in   1              push wr_data this cycle
//  wr_data    in   32             word to transmit
//  tx         out  1              serial line; idle high
//  busy       out  1              1 when FSM is not IDLE
//  fifo_full  out  1              count == FIFO_DEPTH
//  fifo_empty out  1              count == 0
//  fifo_count out  FIFO_AW+1      words queued; excludes the word being sent
//  overflow   out  1              sticky; set when a push is dropped
//  ovf_clr    in   1              synchronous clear of overflow
// BEHAVIOUR
//  Reset (rst low, asynchronous):
//   - tx=1, busy=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0.
//   - FSM goes to IDLE; FIFO pointers, bit counter and byte index are zeroed.
//  Reset mid-frame: tx returns high immediately (async) and the partial word is discarded.
//  All outputs are registered or decoded directly from registers. There is no comb path from inputs.
//  FIFO:
//   - A push when not full stores wr_data at the write pointer, wptr+1 modulo FIFO_DEPTH.
//   - A push when full is dropped, overflow<=1, and FIFO contents are unchanged.
//   - A pop occurs only on the IDLE->START transition.
//   - A simultaneous push and pop is always accepted, even when full; count is unchanged.
//   - ovf_clr and a dropped push in the same cycle: overflow stays 1 (set wins).
//  FSM states: IDLE, START, DATA, STOP.
//   - IDLE: tx=1. If !fifo_empty: load shreg<=head word, pop, byte_idx<=0, go to START.
//     Start-bit latency from a push into an empty idle FIFO is 2 cycles (push edge, then pop edge).
//   - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
//   - DATA: tx = current byte bit bit_idx, LSB first, each bit held CLKS_PER_BIT cycles.
//     After bit 7, go to STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
//     - byte_idx<3: byte_idx+1, shreg>>8, go to START (no gap between bytes).
//     - byte_idx==3: go to IDLE.
//  One word occupies exactly 40*CLKS_PER_BIT cycles from the first start-bit edge to the end of
//  the last stop bit, plus 1 IDLE cycle before the next word's start bit.
//  Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. A bit ends on the cycle the timer is at
//  CLKS_PER_BIT-1. The timer resets to 0 on every state change.
//  tx is driven from a flop: the value for a state appears the cycle after the transition edge.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Release rst; no writes for 50 cycles -> tx=1, busy=0, fifo_empty=1, overflow=0 throughout.
//  2. Push 0x44332211 once -> start bit 2 cycles later.
//     Line bytes 0x11,0x22,0x33,0x44 as 8N1 LSB-first, each bit 4 cycles wide.
//     busy=1 for 160 cycles, then 0.
//  3. Push 6 words on consecutive cycles while idle:
//     - Word 1 is popped; words 2-5 fill the FIFO (fifo_full=1); word 6 is dropped with overflow=1.
//     - Line carries words 1-5 in order, with 1 idle cycle between words.
//  4. Push into a full FIFO in the same cycle as the IDLE->START pop -> the push is accepted,
//     fifo_count stays 4, overflow stays 0.
//  5. Assert rst low mid byte 2 of a word -> tx=1 within the same cycle (async), fifo_count=0.
//     After release, push 0x000000A5 -> a clean frame of A5,00,00,00.
//  6. With overflow=1, assert ovf_clr with no push -> overflow=0 next cycle.
//     ovf_clr together with a dropped push -> overflow stays 1.

Source files
------------

// File: rtl/outport_uart_tx.sv
// Output-port UART transmitter: word FIFO feeding an 8N1 serialiser.
// Each word goes out as four bytes, least significant byte first.
module outport_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4,
   parameter int FIFO_AW      = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [31:0]        wr_data,
   output logic               tx,
   output logic               busy,
   output logic               fifo_full,
   output logic               fifo_empty,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               overflow,
   input  logic               ovf_clr
);

   localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t              state;
   state_t              state_n;
   logic [TW-1:0]       timer;
   logic [TW-1:0]       timer_n;
   logic [2:0]          bit_idx;
   logic [2:0]          bit_n;
   logic [1:0]          byte_idx;
   logic [1:0]          byte_n;
   logic [31:0]         shreg;
   logic [31:0]         shreg_n;
   logic [7:0]          cur_byte;
   logic                tx_n;
   logic                tx_q;
   logic                bit_end;

   logic [31:0]         mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]  wptr;
   logic [FIFO_AW-1:0]  rptr;
   logic [FIFO_AW:0]    count;
   logic                pop;
   logic                push;
   logic                drop;

   // Depth is a power of two, so the count MSB alone flags "full".
   assign fifo_full  = count[FIFO_AW];
   assign fifo_empty = (count == '0);
   assign fifo_count = count;
   assign busy       = (state != IDLE);
   assign tx         = tx_q;

   assign push = wr_en && (!fifo_full || pop);
   assign drop = wr_en && !push;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wptr <= wptr + FIFO_AW'(1);
         if (pop)  rptr <= rptr + FIFO_AW'(1);
         if (push && !pop)
            count <= count + (FIFO_AW+1)'(1);
         else if (pop && !push)
            count <= count - (FIFO_AW+1)'(1);
         if (drop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

   // Storage needs no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wr_data;
   end

   assign bit_end = (timer == T_LAST);

   always_comb begin
      state_n = state;
      timer_n = timer + TW'(1);
      bit_n   = bit_idx;
      byte_n  = byte_idx;
      shreg_n = shreg;
      pop     = 1'b0;
      unique case (state)
         IDLE: begin
            timer_n = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_n = mem[rptr];
               byte_n  = 2'd0;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               timer_n = '0;
               bit_n   = 3'd0;
               state_n = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               timer_n = '0;
               if (bit_idx == 3'd7)
                  state_n = STOP;
               else
                  bit_n = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               timer_n = '0;
               if (byte_idx != 2'd3) begin
                  byte_n  = byte_idx + 2'd1;
                  shreg_n = {8'h00, shreg[31:8]};
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
      endcase
   end

   // Line level is computed from the upcoming state so it lines up with it.
   always_comb begin
      cur_byte = shreg_n[7:0];
      tx_n     = 1'b1;
      unique case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = cur_byte[bit_n];
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         timer    <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         tx_q     <= 1'b1;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         bit_idx  <= bit_n;
         byte_idx <= byte_n;
         shreg    <= shreg_n;
         tx_q     <= tx_n;
      end
   end

endmodule

// File: tb/tb_outport_uart_tx.sv
// Bench for outport_uart_tx: random words checked against an ideal
// 8N1 line waveform and a simple FIFO occupancy model.
module tb_outport_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [31:0]   wr_data = '0;
   logic          ovf_clr = 1'b0;
   logic          tx;
   logic          busy;
   logic          fifo_full;
   logic          fifo_empty;
   logic [AW:0]   fifo_count;
   logic          overflow;

   int n_checks = 0;
   int n_fail   = 0;

   logic cap_tx[$];
   logic cap_busy[$];
   logic exp_tx[$];
   logic exp_busy[$];

   always #5 clk = ~clk;

   outport_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .FIFO_AW      (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .tx         (tx),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   function automatic void exp_clear();
      exp_tx.delete();
      exp_busy.delete();
   endfunction

   function automatic void exp_idle(input int n);
      for (int i = 0; i < n; i++) begin
         exp_tx.push_back(1'b1);
         exp_busy.push_back(1'b0);
      end
   endfunction

   // One idle cycle (popping), then four 10-bit frames, CPB cycles per bit.
   function automatic void exp_word(input logic [31:0] w);
      logic v;
      exp_idle(1);
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 10; k++) begin
            if (k == 0) v = 1'b0;
            else if (k == 9) v = 1'b1;
            else v = w[8*b + k - 1];
            for (int c = 0; c < CPB; c++) begin
               exp_tx.push_back(v);
               exp_busy.push_back(1'b1);
            end
         end
      end
   endfunction

   // Starts at the next rising edge, samples on each falling edge after it.
   task automatic capture(input int n);
      cap_tx.delete();
      cap_busy.delete();
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cap_tx.push_back(tx);
         cap_busy.push_back(busy);
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if ({tx, busy, fifo_empty, fifo_full, overflow, fifo_count} !== {5'b10100, 3'd0}) begin
         n_fail++;
         $display("FAIL reset_state: got tx=%b busy=%b empty=%b full=%b ovf=%b cnt=%0d required 1 0 1 0 0 0",
                  tx, busy, fifo_empty, fifo_full, overflow, fifo_count);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n_checks++;
         if ({tx, busy, fifo_empty, overflow} !== 4'b1010) begin
            n_fail++;
            $display("FAIL idle_quiet[%0d]: got tx=%b busy=%b empty=%b ovf=%b required 1 0 1 0",
                     i, tx, busy, fifo_empty, overflow);
         end
      end
   endtask

   task automatic test_single();
      exp_clear();
      exp_word(32'h44332211);
      exp_idle(10);
      @(posedge clk); #1;
      wr_en = 1'b1;
      wr_data = 32'h44332211;
      fork
         begin
            @(posedge clk); #1;
            wr_en = 1'b0;
         end
         capture(exp_tx.size());
      join
      for (int i = 0; i < exp_tx.size(); i++) begin
         n_checks++;
         if (cap_tx[i] !== exp_tx[i] || cap_busy[i] !== exp_busy[i]) begin
            n_fail++;
            $display("FAIL single_line[%0d]: got tx=%b busy=%b required tx=%b busy=%b",
                     i, cap_tx[i], cap_busy[i], exp_tx[i], exp_busy[i]);
         end
      end
   endtask

   task automatic test_burst();
      logic [31:0] w[6];
      logic [31:0] acc[$];
      int          occ;
      bit          pop_now;
      bit          take;
      bit          any_drop;
      occ = 0;
      any_drop = 1'b0;
      for (int i = 0; i < 6; i++) begin
         w[i] = $urandom;
         pop_now = (i == 1);
         take = (occ < DEPTH) || pop_now;
         if (take) acc.push_back(w[i]);
         else any_drop = 1'b1;
         occ = occ + int'(take) - int'(pop_now);
      end
      exp_clear();
      foreach (acc[i]) exp_word(acc[i]);
      exp_idle(4);
      @(posedge clk); #1;
      wr_en = 1'b1;
      wr_data = w[0];
      fork
         begin
            for (int i = 1; i < 6; i++) begin
               @(posedge clk); #1;
               wr_data = w[i];
            end
            @(posedge clk); #1;
            wr_en = 1'b0;
            @(negedge clk);
            n_checks++;
            if (fifo_count !== 3'(occ) || fifo_full !== 1'b1 || overflow !== any_drop) begin
               n_fail++;
               $display("FAIL burst_fifo: got cnt=%0d full=%b ovf=%b required cnt=%0d full=1 ovf=%b",
                        fifo_count, fifo_full, overflow, occ, any_drop);
            end
         end
         capture(exp_tx.size());
      join
      for (int i = 0; i < exp_tx.size(); i++) begin
         n_checks++;
         if (cap_tx[i] !== exp_tx[i] || cap_busy[i] !== exp_busy[i]) begin
            n_fail++;
            $display("FAIL burst_line[%0d]: got tx=%b busy=%b required tx=%b busy=%b",
                     i, cap_tx[i], cap_busy[i], exp_tx[i], exp_busy[i]);
         end
      end
   endtask

   task automatic test_ovf_clr();
      bit drained;
      @(negedge clk);
      n_checks++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky: got %b required 1", overflow);
      end
      @(posedge clk); #1;
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: got %b required 0", overflow);
      end
      @(posedge clk); #1;
      wr_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_data = $urandom;
         ovf_clr = (i == 5);
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
      ovf_clr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
         n_fail++;
         $display("FAIL ovf_set_wins: got ovf=%b cnt=%0d required ovf=1 cnt=4", overflow, fifo_count);
      end
      @(posedge clk); #1;
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear_busy: got %b required 0", overflow);
      end
      drained = 1'b0;
      for (int t = 0; t < 2000 && !drained; t++) begin
         @(negedge clk);
         if (!busy && fifo_empty) drained = 1'b1;
      end
      n_checks++;
      if (!drained) begin
         n_fail++;
         $display("FAIL drain_timeout: got busy=%b empty=%b required 0 1", busy, fifo_empty);
      end
   endtask

   task automatic test_full_pop();
      logic [31:0] w[6];
      bit          found;
      for (int i = 0; i < 6; i++) w[i] = $urandom;
      exp_clear();
      for (int i = 0; i < 6; i++) exp_word(w[i]);
      exp_idle(4);
      @(posedge clk); #1;
      wr_en = 1'b1;
      wr_data = w[0];
      fork
         begin
            for (int i = 1; i < 5; i++) begin
               @(posedge clk); #1;
               wr_data = w[i];
            end
            @(posedge clk); #1;
            wr_en = 1'b0;
            found = 1'b0;
            for (int t = 0; t < 400 && !found; t++) begin
               @(negedge clk);
               if (!busy && fifo_full) found = 1'b1;
            end
            n_checks++;
            if (!found) begin
               n_fail++;
               $display("FAIL full_idle_timeout: got busy=%b full=%b required 0 1", busy, fifo_full);
            end else begin
               wr_en = 1'b1;
               wr_data = w[5];
               @(posedge clk); #1;
               wr_en = 1'b0;
               @(negedge clk);
               n_checks++;
               if (fifo_count !== 3'd4 || overflow !== 1'b0 || busy !== 1'b1) begin
                  n_fail++;
                  $display("FAIL full_push_pop: got cnt=%0d ovf=%b busy=%b required 4 0 1",
                           fifo_count, overflow, busy);
               end
            end
         end
         capture(exp_tx.size());
      join
      for (int i = 0; i < exp_tx.size(); i++) begin
         n_checks++;
         if (cap_tx[i] !== exp_tx[i] || cap_busy[i] !== exp_busy[i]) begin
            n_fail++;
            $display("FAIL full_pop_line[%0d]: got tx=%b busy=%b required tx=%b busy=%b",
                     i, cap_tx[i], cap_busy[i], exp_tx[i], exp_busy[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      wr_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = $urandom;
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
      repeat (81) @(negedge clk);
      n_checks++;
      if (tx !== 1'b0 || fifo_count !== 3'd2) begin
         n_fail++;
         $display("FAIL pre_reset: got tx=%b cnt=%0d required tx=0 cnt=2", tx, fifo_count);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({tx, busy, fifo_empty, fifo_count} !== {3'b101, 3'd0}) begin
         n_fail++;
         $display("FAIL async_reset: got tx=%b busy=%b empty=%b cnt=%0d required 1 0 1 0",
                  tx, busy, fifo_empty, fifo_count);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      exp_clear();
      exp_word(32'h000000A5);
      exp_idle(20);
      @(posedge clk); #1;
      wr_en = 1'b1;
      wr_data = 32'h000000A5;
      fork
         begin
            @(posedge clk); #1;
            wr_en = 1'b0;
         end
         capture(exp_tx.size());
      join
      for (int i = 0; i < exp_tx.size(); i++) begin
         n_checks++;
         if (cap_tx[i] !== exp_tx[i] || cap_busy[i] !== exp_busy[i]) begin
            n_fail++;
            $display("FAIL post_reset_line[%0d]: got tx=%b busy=%b required tx=%b busy=%b",
                     i, cap_tx[i], cap_busy[i], exp_tx[i], exp_busy[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_ovf_clr();
      test_full_pop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
